// File: rtl/matmul_sequencer.sv
// Control sequencer for the 8x8 matrix-vector MAC datapath: streams operands into memory,
// issues one dot product per row and emits each rescaled, saturated row result.
module matmul_sequencer #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDRS_LEN = 7,
    parameter int unsigned N         = 8,
    parameter int unsigned QF        = 8,
    parameter int unsigned ACC_W     = 2 * WORD_SIZE + 3
) (
    input  logic                    i_src_clk,
    input  logic                    i_rst_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [WORD_SIZE-1:0]    i_in_data,
    output logic                    o_mem_we,
    output logic [ADDRS_LEN-1:0]    o_mem_addr,
    output logic [WORD_SIZE-1:0]    o_mem_wdata,
    output logic [ADDRS_LEN-1:0]    o_rd_addr_a,
    output logic [ADDRS_LEN-1:0]    o_rd_addr_b,
    output logic                    o_mac_clr,
    output logic                    o_mac_en,
    input  logic signed [ACC_W-1:0] i_acc_in,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [WORD_SIZE-1:0]    o_out_data,
    output logic [$clog2(N)-1:0]    o_out_row,
    output logic                    o_out_last,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [ADDRS_LEN-1:0] VEC_BASE   = ADDRS_LEN'(N * N);
    localparam logic [ADDRS_LEN-1:0] LOAD_LAST  = ADDRS_LEN'(N * N + N - 1);
    localparam logic [ADDRS_LEN-1:0] ROW_STRIDE = ADDRS_LEN'(N);
    localparam logic [ADDRS_LEN-1:0] ADDR_ONE   = ADDRS_LEN'(1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE    = IDX_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - WORD_SIZE + 1){1'b0}}, {(WORD_SIZE - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - WORD_SIZE + 1){1'b1}}, {(WORD_SIZE - 1){1'b0}}};

    typedef enum logic [1:0] {StLoad, StIssue, StFlush, StEmit} state_t;

    state_t                 r_state;
    logic [ADDRS_LEN-1:0]   r_count;
    logic [IDX_W-1:0]       r_row;
    logic [IDX_W-1:0]       r_k;
    logic                   r_flush;
    logic                   r_in_ready;
    logic                   r_mem_we;
    logic [ADDRS_LEN-1:0]   r_mem_addr;
    logic [WORD_SIZE-1:0]   r_mem_wdata;
    logic [ADDRS_LEN-1:0]   r_rd_addr_a;
    logic [ADDRS_LEN-1:0]   r_rd_addr_b;
    logic                   r_mac_clr;
    logic                   r_mac_en;
    logic                   r_out_valid;
    logic [WORD_SIZE-1:0]   r_out_data;
    logic [IDX_W-1:0]       r_out_row;
    logic                   r_out_last;
    logic                   r_busy;
    logic                   r_done;

    logic signed [ACC_W-1:0] w_shifted;
    logic [WORD_SIZE-1:0]    w_sat;
    logic [IDX_W-1:0]        w_next_row;
    logic [ADDRS_LEN-1:0]    w_row_base;
    logic [ADDRS_LEN-1:0]    w_next_base;

    assign w_next_row  = r_row + IDX_ONE;
    assign w_row_base  = ADDRS_LEN'(r_row) * ROW_STRIDE;
    assign w_next_base = ADDRS_LEN'(w_next_row) * ROW_STRIDE;

    // Accumulator is Q(2*QF); arithmetic shift floors toward -inf before clamping.
    always_comb begin
        w_shifted = i_acc_in >>> QF;
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[WORD_SIZE-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[WORD_SIZE-1:0];
        end else begin
            w_sat = w_shifted[WORD_SIZE-1:0];
        end
    end

    always_ff @(posedge i_src_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StLoad;
            r_count     <= '0;
            r_row       <= '0;
            r_k         <= '0;
            r_flush     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_mac_clr   <= 1'b0;
            r_mac_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mem_we  <= 1'b0;
            r_mac_en  <= 1'b0;
            r_mac_clr <= 1'b0;
            r_done    <= 1'b0;
            unique case (r_state)
                StLoad: begin
                    if (i_in_valid && r_in_ready) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_count;
                        r_mem_wdata <= i_in_data;
                        if (r_count == LOAD_LAST) begin
                            r_state     <= StIssue;
                            r_k         <= '0;
                            r_in_ready  <= 1'b0;
                            r_busy      <= 1'b1;
                            r_rd_addr_a <= w_row_base;
                            r_rd_addr_b <= VEC_BASE;
                        end else begin
                            r_count <= r_count + ADDR_ONE;
                        end
                    end
                end
                StIssue: begin
                    // Read data for this beat returns next cycle, so the MAC strobe lags by one.
                    r_mac_en  <= 1'b1;
                    r_mac_clr <= (r_k == '0);
                    if (r_k == IDX_LAST) begin
                        r_state <= StFlush;
                        r_flush <= 1'b0;
                    end else begin
                        r_k         <= r_k + IDX_ONE;
                        r_rd_addr_a <= r_rd_addr_a + ADDR_ONE;
                        r_rd_addr_b <= r_rd_addr_b + ADDR_ONE;
                    end
                end
                StFlush: begin
                    if (!r_flush) begin
                        r_flush <= 1'b1;
                    end else begin
                        r_out_data  <= w_sat;
                        r_out_valid <= 1'b1;
                        r_out_row   <= r_row;
                        r_out_last  <= (r_row == IDX_LAST);
                        r_state     <= StEmit;
                    end
                end
                StEmit: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_row != IDX_LAST) begin
                            r_row       <= w_next_row;
                            r_k         <= '0;
                            r_state     <= StIssue;
                            r_rd_addr_a <= w_next_base;
                            r_rd_addr_b <= VEC_BASE;
                        end else begin
                            r_done     <= 1'b1;
                            r_row      <= '0;
                            r_count    <= '0;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= StLoad;
                        end
                    end
                end
                default: r_state <= StLoad;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rd_addr_a = r_rd_addr_a;
    assign o_rd_addr_b = r_rd_addr_b;
    assign o_mac_clr   = r_mac_clr;
    assign o_mac_en    = r_mac_en;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_row   = r_out_row;
    assign o_out_last  = r_out_last;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: memory + MAC environment model, reference
// matrix-vector product with rescale and saturation, cycle-exact schedule checks.
module tb_matmul_sequencer;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_data;
    logic               mem_we;
    logic [6:0]         mem_addr;
    logic [15:0]        mem_wdata;
    logic [6:0]         rd_a;
    logic [6:0]         rd_b;
    logic               mac_clr;
    logic               mac_en;
    logic signed [34:0] acc;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_data;
    logic [2:0]         out_row;
    logic               out_last;
    logic               busy;
    logic               done;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] ma [64];
    logic [15:0] vb [8];
    logic [6:0]  wq_addr [$];
    logic [15:0] wq_data [$];
    bit          log_writes = 1'b0;

    matmul_sequencer dut (
        .i_src_clk  (clk),
        .i_rst_n    (rst_n),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_data  (in_data),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_rd_addr_a(rd_a),
        .o_rd_addr_b(rd_b),
        .o_mac_clr  (mac_clr),
        .o_mac_en   (mac_en),
        .i_acc_in   (acc),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_data (out_data),
        .o_out_row  (out_row),
        .o_out_last (out_last),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Operand memory (1-cycle read) and MAC accumulator driven by the sequencer.
    logic signed [15:0] mem [128];
    logic signed [15:0] rda;
    logic signed [15:0] rdb;
    logic signed [34:0] prod;
    assign prod = rda * rdb;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rda <= mem[rd_a];
        rdb <= mem[rd_b];
        if (mac_en) acc <= mac_clr ? prod : acc + prod;
    end

    always @(negedge clk) begin
        if (log_writes && mem_we === 1'b1) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_row(input int r);
        longint s = 0;
        for (int k = 0; k < 8; k++)
            s += longint'($signed(ma[r * 8 + k])) * longint'($signed(vb[k]));
        s = s >>> 8;
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    function automatic void fill_random(input bit big);
        for (int i = 0; i < 64; i++)
            ma[i] = big ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
        for (int i = 0; i < 8; i++)
            vb[i] = big ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
    endfunction

    task automatic load_operands(input bit gaps);
        for (int i = 0; i < 72; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = (i < 64) ? ma[i] : vb[i - 64];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Starts in cycle t0 of row 0; checks every cycle of each row's schedule.
    task automatic run_rows(input int stall_row, input int stop_row);
        logic [15:0] exp;
        for (int r = 0; r < 8; r++) begin
            exp = ref_row(r);
            if (r == stall_row) out_ready = 1'b0;
            for (int c = 0; c <= 10; c++) begin
                @(negedge clk);
                n_cmp++;
                if (mac_en !== ((c >= 1 && c <= 8) ? 1'b1 : 1'b0)) begin
                    n_err++;
                    $display("FAIL mac_en row%0d t0+%0d: got %b want %b", r, c, mac_en,
                             (c >= 1 && c <= 8));
                end
                n_cmp++;
                if (mac_clr !== ((c == 1) ? 1'b1 : 1'b0)) begin
                    n_err++;
                    $display("FAIL mac_clr row%0d t0+%0d: got %b want %b", r, c, mac_clr, c == 1);
                end
                n_cmp++;
                if (out_valid !== ((c == 10) ? 1'b1 : 1'b0)) begin
                    n_err++;
                    $display("FAIL out_valid row%0d t0+%0d: got %b want %b", r, c, out_valid,
                             c == 10);
                end
                n_cmp++;
                if ({in_ready, busy, done} !== 3'b010) begin
                    n_err++;
                    $display("FAIL status row%0d t0+%0d: got in_ready/busy/done %b want 010",
                             r, c, {in_ready, busy, done});
                end
                if (c <= 7) begin
                    n_cmp++;
                    if ({rd_a, rd_b} !== {7'(r * 8 + c), 7'(64 + c)}) begin
                        n_err++;
                        $display("FAIL rd_addr row%0d k%0d: got a=%0d b=%0d want a=%0d b=%0d",
                                 r, c, rd_a, rd_b, r * 8 + c, 64 + c);
                    end
                end
                if (c >= 1) begin
                    n_cmp++;
                    if (mem_we !== 1'b0) begin
                        n_err++;
                        $display("FAIL mem_we_busy row%0d t0+%0d: got %b want 0", r, c, mem_we);
                    end
                end
                if (c == 10) begin
                    n_cmp++;
                    if ({out_data, out_row, out_last} !== {exp, 3'(r), (r == 7)}) begin
                        n_err++;
                        $display("FAIL result row%0d: got data=%h row=%0d last=%b want %h %0d %b",
                                 r, out_data, out_row, out_last, exp, r, r == 7);
                    end
                end
                if (r == stop_row && c == 3) begin
                    in_valid = 1'b0;
                    return;
                end
                in_valid = (c < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (c < 10) begin
                    @(posedge clk); #1;
                end
            end
            if (r == stall_row) begin
                for (int s = 0; s < 4; s++) begin
                    @(posedge clk);
                    @(negedge clk);
                    n_cmp++;
                    if ({out_valid, out_data, out_row, mac_en} !== {1'b1, exp, 3'(r), 1'b0}) begin
                        n_err++;
                        $display("FAIL stall_hold row%0d s%0d: got v=%b d=%h r=%0d en=%b want 1 %h %0d 0",
                                 r, s, out_valid, out_data, out_row, mac_en, exp, r);
                    end
                    n_cmp++;
                    if ({rd_a, rd_b} !== {7'(r * 8 + 7), 7'd71}) begin
                        n_err++;
                        $display("FAIL stall_rd row%0d: got a=%0d b=%0d want %0d 71",
                                 r, rd_a, rd_b, r * 8 + 7);
                    end
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            if (r == 7) begin
                @(negedge clk);
                n_cmp++;
                if ({done, out_valid, busy, in_ready} !== 4'b1001) begin
                    n_err++;
                    $display("FAIL done_pulse: got done/valid/busy/in_ready %b want 1001",
                             {done, out_valid, busy, in_ready});
                end
                @(negedge clk);
                n_cmp++;
                if (done !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_width: got %b want 0", done);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        logic [63:0] obs;
        #12;
        obs = {in_ready, mem_we, mem_addr, mem_wdata, rd_a, rd_b, mac_clr, mac_en, out_valid,
               out_data, out_row, out_last, busy, done};
        n_cmp++;
        if (obs !== 64'h8000_0000_0000_0000) begin
            n_err++;
            $display("FAIL reset_values: got %h want 8000000000000000", obs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        obs = {in_ready, mem_we, mem_addr, mem_wdata, rd_a, rd_b, mac_clr, mac_en, out_valid,
               out_data, out_row, out_last, busy, done};
        n_cmp++;
        if (obs !== 64'h8000_0000_0000_0000) begin
            n_err++;
            $display("FAIL idle_after_reset: got %h want 8000000000000000", obs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        for (int i = 0; i < 64; i++) ma[i] = (i % 9 == 0) ? 16'h0100 : 16'h0000;
        for (int k = 0; k < 8; k++) vb[k] = 16'h0100 * 16'(k + 1);
        load_operands(1'b0);
        run_rows(-1, -1);
    endtask

    task automatic test_load_gaps();
        fill_random(1'b0);
        wq_addr.delete();
        wq_data.delete();
        log_writes = 1'b1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_in_load: got %b want 0", busy);
        end
        load_operands(1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_rise: got %b want 1", busy);
        end
        run_rows(-1, -1);
        log_writes = 1'b0;
        n_cmp++;
        if (wq_addr.size() != 72) begin
            n_err++;
            $display("FAIL write_count: got %0d want 72", wq_addr.size());
        end else begin
            for (int i = 0; i < 72; i++) begin
                n_cmp++;
                if ({wq_addr[i], wq_data[i]} !== {7'(i), (i < 64) ? ma[i] : vb[i - 64]}) begin
                    n_err++;
                    $display("FAIL write%0d: got addr=%0d data=%h want %0d %h", i, wq_addr[i],
                             wq_data[i], i, (i < 64) ? ma[i] : vb[i - 64]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 64; i++) ma[i] = 16'h7FFF;
        for (int k = 0; k < 8; k++) vb[k] = 16'h7FFF;
        load_operands(1'b0);
        run_rows(-1, -1);
        for (int i = 0; i < 64; i++) ma[i] = 16'h8000;
        load_operands(1'b0);
        run_rows(-1, -1);
        for (int i = 0; i < 64; i++) ma[i] = (i % 9 == 0) ? 16'hFF00 : 16'h0000;
        for (int k = 0; k < 8; k++) vb[k] = 16'h0180;
        load_operands(1'b0);
        run_rows(-1, -1);
    endtask

    task automatic test_backpressure();
        fill_random(1'b0);
        load_operands(1'b0);
        run_rows(3, -1);
    endtask

    task automatic test_reset_mid();
        logic [63:0] obs;
        fill_random(1'b0);
        load_operands(1'b0);
        run_rows(-1, 2);
        #2 rst_n = 1'b0;
        #1;
        obs = {in_ready, mem_we, mem_addr, mem_wdata, rd_a, rd_b, mac_clr, mac_en, out_valid,
               out_data, out_row, out_last, busy, done};
        n_cmp++;
        if (obs !== 64'h8000_0000_0000_0000) begin
            n_err++;
            $display("FAIL reset_mid: got %h want 8000000000000000", obs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_random(1'b0);
        load_operands(1'b0);
        run_rows(-1, -1);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            fill_random(n == 1);
            load_operands(n == 2);
            run_rows(-1, -1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        test_reset();
        test_identity();
        test_load_gaps();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
